// File: rtl/dhms_seg_scan.sv
// Multiplexed 8-digit 7-segment driver for a day/hour/minute/second counter.
// Optional macro DP_BLINK_EN: separator points follow the snapshot's sec[0].
module dhms_seg_scan #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] day,
  input  logic [4:0] hrs,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [15:0] CNT_LAST = 16'(SCAN_DIV - 1);

  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [4:0]  snap_day;
  logic [4:0]  snap_hrs;
  logic [5:0]  snap_min;
  logic [5:0]  snap_sec;

  logic [5:0]  field_p0;
  logic        legal_p0;
  logic [3:0]  tens_p0;
  logic [3:0]  ones_p0;
  logic [5:0]  tens6_p0;
  logic [5:0]  ones6_p0;
  logic [7:0]  an_p0;
  logic [6:0]  seg_p0;
  logic        dp_p0;
  logic        slot_last;

  function automatic logic [3:0] tens_of(input logic [5:0] v);
    if (v >= 6'd60)      return 4'd6;
    else if (v >= 6'd50) return 4'd5;
    else if (v >= 6'd40) return 4'd4;
    else if (v >= 6'd30) return 4'd3;
    else if (v >= 6'd20) return 4'd2;
    else if (v >= 6'd10) return 4'd1;
    else                 return 4'd0;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  assign slot_last = (cnt == CNT_LAST);

  // Stage 0: decode the digit selected by the current (cnt, idx)
  always_comb begin
    field_p0 = snap_sec;
    legal_p0 = 1'b1;
    unique case (idx[2:1])
      2'd0: begin field_p0 = snap_sec;         legal_p0 = (snap_sec <= 6'd59); end
      2'd1: begin field_p0 = snap_min;         legal_p0 = (snap_min <= 6'd59); end
      2'd2: begin field_p0 = {1'b0, snap_hrs}; legal_p0 = (snap_hrs <= 5'd23); end
      default: begin
        field_p0 = {1'b0, snap_day};
        legal_p0 = (snap_day >= 5'd1) && (snap_day <= 5'd30);
      end
    endcase
    tens_p0  = tens_of(field_p0);
    tens6_p0 = {2'b00, tens_p0};
    ones6_p0 = field_p0 - ((tens6_p0 << 3) + (tens6_p0 << 1));
    ones_p0  = ones6_p0[3:0];
    seg_p0   = legal_p0 ? seg7(idx[0] ? tens_p0 : ones_p0) : 7'h3F;
    an_p0    = (cnt == 16'd0) ? 8'hFF : ~(8'h01 << idx);
    dp_p0    = 1'b1;
    if (!idx[0] && (idx != 3'd0)) begin
`ifdef DP_BLINK_EN
      dp_p0 = snap_sec[0];
`else
      dp_p0 = 1'b0;
`endif
    end
  end

  // Stage 1: scan counters, frame snapshot and registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      idx      <= '0;
      snap_day <= 5'd1;
      snap_hrs <= '0;
      snap_min <= '0;
      snap_sec <= '0;
      an       <= 8'hFF;
      seg      <= 7'h7F;
      dp       <= 1'b1;
    end else begin
      an  <= an_p0;
      seg <= seg_p0;
      dp  <= dp_p0;
      if (slot_last) begin
        cnt <= '0;
        idx <= idx + 3'd1;
        // Capture all fields together so a frame never mixes two times
        if (idx == 3'd7) begin
          snap_day <= day;
          snap_hrs <= hrs;
          snap_min <= min;
          snap_sec <= sec;
        end
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule
